// File: rtl/vsm_pkg.sv
// vsm_pkg: shared definitions for the VSM control unit and its datapath blocks.
//   - vsmState_t : FSM state encodings (3-bit)
//   - OP_*       : 4-bit opcode constants NOP..HALT
//   - ALU_*      : AluOp codes (ADD, SUB, idle)
//   - ctrl_t     : bundle of every control output driven by the control unit
package vsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC1  = 3'd3,
        ST_EXEC2  = 3'd4,
        ST_HALT   = 3'd5
    } vsmState_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDA   = 4'h1;
    localparam logic [3:0] OP_LDB   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_STA   = 4'h5;
    localparam logic [3:0] OP_CLRA  = 4'h6;
    localparam logic [3:0] OP_MOVAB = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_IDLE = 2'b11;

    typedef struct packed {
        logic       clearA;
        logic       latchA;
        logic       enableA;
        logic       latchB;
        logic       enableB;
        logic [1:0] aluOp;
        logic       aluEnable;
        logic       memRead;
        logic       memWrite;
        logic       latchIR;
        logic       pcInc;
        logic       halted;
        logic       illegalOp;
    } ctrl_t;

    // Quiescent control word: every strobe low, ALU parked on its idle code.
    localparam ctrl_t CTRL_IDLE = '{aluOp: ALU_IDLE, default: '0};

endpackage

// File: rtl/vsm_op_decode.sv
// vsm_op_decode: combinational opcode decode for the EXEC1 cycle.
// Ports:
//   ir        in  [3:0] latched opcode
//   exec1Ctrl out       control word to drive during EXEC1
//   toExec2   out       instruction needs a second execute cycle (STA)
//   toHalt    out       instruction halts the machine
module vsm_op_decode
    import vsm_pkg::*;
(
    input  logic [3:0] ir,
    output ctrl_t      exec1Ctrl,
    output logic       toExec2,
    output logic       toHalt
);

    always_comb begin
        exec1Ctrl = CTRL_IDLE;
        toExec2   = 1'b0;
        toHalt    = 1'b0;
        case (ir)
            OP_NOP: ;
            OP_LDA: begin
                exec1Ctrl.memRead = 1'b1;
                exec1Ctrl.latchA  = 1'b1;
            end
            OP_LDB: begin
                exec1Ctrl.memRead = 1'b1;
                exec1Ctrl.latchB  = 1'b1;
            end
            OP_ADD: begin
                exec1Ctrl.aluOp     = ALU_ADD;
                exec1Ctrl.aluEnable = 1'b1;
                exec1Ctrl.latchA    = 1'b1;
            end
            OP_SUB: begin
                exec1Ctrl.aluOp     = ALU_SUB;
                exec1Ctrl.aluEnable = 1'b1;
                exec1Ctrl.latchA    = 1'b1;
            end
            OP_STA: begin
                // A is put on the bus one cycle early so it is settled when
                // memory captures it in EXEC2.
                exec1Ctrl.enableA = 1'b1;
                toExec2           = 1'b1;
            end
            OP_CLRA:  exec1Ctrl.clearA = 1'b1;
            OP_MOVAB: begin
                exec1Ctrl.enableA = 1'b1;
                exec1Ctrl.latchB  = 1'b1;
            end
            OP_HALT:  toHalt = 1'b1;
            // 8..E: flagged for one cycle, otherwise treated as NOP.
            default:  exec1Ctrl.illegalOp = 1'b1;
        endcase
    end

endmodule

// File: rtl/vsm_control_unit.sv
// vsm_control_unit: Moore FSM sequencing FETCH / DECODE / EXEC for the VSM.
// Ports:
//   MainClock, ResetN       clock, async active-low reset
//   Start                   leave IDLE (only looked at in IDLE)
//   IB[3:0]                 internal bus, captured into IR during FETCH
//   ClearA LatchA EnableA   accumulator controls
//   LatchB EnableB          register B controls
//   AluOp[1:0] AluEnable    ALU operation / ALU drives A input path
//   MemRead MemWrite        memory drive / capture
//   LatchIR PcInc           IR load / PC increment
//   Halted IllegalOp        halt level / illegal-opcode pulse
// All outputs decode from state and IR only, so reset clears them at once.
module vsm_control_unit
    import vsm_pkg::*;
(
    input  logic       MainClock,
    input  logic       ResetN,
    input  logic       Start,
    input  logic [3:0] IB,
    output logic       ClearA,
    output logic       LatchA,
    output logic       EnableA,
    output logic       LatchB,
    output logic       EnableB,
    output logic [1:0] AluOp,
    output logic       AluEnable,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       LatchIR,
    output logic       PcInc,
    output logic       Halted,
    output logic       IllegalOp
);

    vsmState_t  state, nextState;
    logic [3:0] ir;
    ctrl_t      ctrl, exec1Ctrl;
    logic       toExec2, toHalt;

    vsm_op_decode uDecode (
        .ir        (ir),
        .exec1Ctrl (exec1Ctrl),
        .toExec2   (toExec2),
        .toHalt    (toHalt)
    );

    always_ff @(posedge MainClock or negedge ResetN) begin
        if (!ResetN) begin
            state <= ST_IDLE;
            ir    <= 4'h0;
        end else begin
            state <= nextState;
            if (state == ST_FETCH)
                ir <= IB;
        end
    end

    always_comb begin
        nextState = ST_IDLE;
        ctrl      = CTRL_IDLE;
        case (state)
            ST_IDLE:   nextState = Start ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.latchIR = 1'b1;
                nextState    = ST_DECODE;
            end
            ST_DECODE: begin
                ctrl.pcInc = 1'b1;
                nextState  = ST_EXEC1;
            end
            ST_EXEC1: begin
                ctrl = exec1Ctrl;
                if (toHalt)
                    nextState = ST_HALT;
                else if (toExec2)
                    nextState = ST_EXEC2;
                else
                    nextState = ST_FETCH;
            end
            ST_EXEC2: begin
                ctrl.enableA  = 1'b1;
                ctrl.memWrite = 1'b1;
                nextState     = ST_FETCH;
            end
            // Sticky until reset; Start is deliberately not looked at here.
            ST_HALT: begin
                ctrl.halted = 1'b1;
                nextState   = ST_HALT;
            end
            // Unused encodings fall back to IDLE with controls quiet.
            default:   nextState = ST_IDLE;
        endcase
    end

    assign ClearA    = ctrl.clearA;
    assign LatchA    = ctrl.latchA;
    assign EnableA   = ctrl.enableA;
    assign LatchB    = ctrl.latchB;
    assign EnableB   = ctrl.enableB;
    assign AluOp     = ctrl.aluOp;
    assign AluEnable = ctrl.aluEnable;
    assign MemRead   = ctrl.memRead;
    assign MemWrite  = ctrl.memWrite;
    assign LatchIR   = ctrl.latchIR;
    assign PcInc     = ctrl.pcInc;
    assign Halted    = ctrl.halted;
    assign IllegalOp = ctrl.illegalOp;

endmodule

// File: doc/vsm_control_unit.md
VSM_CONTROL_UNIT -- requirements
Module: vsm_control_unit

Interface
REQ-001 SHALL: MainClock  input  1  single system clock; all state changes on the rising edge.
REQ-002 SHALL: ResetN  input  1  asynchronous active-low reset.
REQ-003 SHALL: Start  input  1  begin execution from IDLE; sampled only in IDLE.
REQ-004 SHALL: IB[3:0]  input  4  internal bus, sampled as opcode while LatchIR=1.
REQ-005 SHALL: ClearA, LatchA, EnableA  output  1 each  accumulator A controls: clear, load at clock, drive IB.
REQ-006 SHALL: LatchB, EnableB  output  1 each  register B load and drive-IB controls.
REQ-007 SHALL: AluOp[1:0]  output  2  ALU operation: 00 ADD, 01 SUB, 11 idle.
REQ-008 SHALL: AluEnable  output  1  ALU result drives the A input path.
REQ-009 SHALL: MemRead, MemWrite  output  1 each  memory drives IB / memory captures IB.
REQ-010 SHALL: LatchIR, PcInc  output  1 each  instruction register load / program counter increment.
REQ-011 SHALL: Halted, IllegalOp  output  1 each  halt status level / one-cycle illegal-opcode pulse.

Function
REQ-012 SHALL: states are IDLE, FETCH, DECODE, EXEC1, EXEC2, HALT, held in a 3-bit state register; the opcode is held in a 4-bit IR.
REQ-013 SHALL: all outputs are Moore functions of state and IR only; no output depends combinationally on Start or IB.
REQ-014 SHALL: IDLE: all controls 0, AluOp=11; go to FETCH when Start=1, else remain in IDLE.
REQ-015 SHALL: FETCH: MemRead=1, LatchIR=1; IR<=IB at the edge; next state DECODE.
REQ-016 SHALL: DECODE: PcInc=1; next state EXEC1.
REQ-017 SHALL: in EXEC1, opcode 0 NOP asserts no controls; next state FETCH.
REQ-018 SHALL: in EXEC1, opcode 1 LDA asserts MemRead and LatchA; next state FETCH.
REQ-019 SHALL: in EXEC1, opcode 2 LDB asserts MemRead and LatchB; next state FETCH.
REQ-020 SHALL: in EXEC1, opcode 3 ADD asserts AluOp=00, AluEnable and LatchA; next state FETCH.
REQ-021 SHALL: in EXEC1, opcode 4 SUB asserts AluOp=01, AluEnable and LatchA; next state FETCH.
REQ-022 SHALL: opcode 5 STA asserts EnableA in EXEC1 and goes to EXEC2; EXEC2 asserts EnableA and MemWrite, then goes to FETCH.
REQ-023 SHALL: in EXEC1, opcode 6 CLRA asserts ClearA; next state FETCH.
REQ-024 SHALL: in EXEC1, opcode 7 MOVAB asserts EnableA and LatchB; next state FETCH.
REQ-025 SHALL: in EXEC1, opcode F HALT asserts no controls; next state HALT.
REQ-026 SHALL: in EXEC1, opcodes 8-E assert IllegalOp for exactly that cycle, behave as NOP, and go to FETCH.
REQ-027 SHALL: HALT holds Halted=1 with all other controls 0; Start is ignored; only ResetN exits HALT.
REQ-028 SHALL: bus exclusivity: in every cycle at most one of EnableA, EnableB, MemRead, AluEnable is 1.
REQ-029 SHALL: LatchA and ClearA are never 1 in the same cycle.
REQ-030 SHALL: instruction latency is 3 cycles (FETCH..EXEC1), or 4 for STA; Start pulses outside IDLE have no effect.
REQ-031 SHALL: unused state encodings go to IDLE on the next edge with all controls 0.

Reset
REQ-032 SHALL: ResetN=0 immediately forces state IDLE, IR=0, all 1-bit outputs 0 and AluOp=11, regardless of clock.
REQ-033 SHALL: reset asserted mid-instruction (including EXEC2 of STA) aborts it with no further MemWrite; after release the block waits in IDLE for Start.

Structure
REQ-034 SHALL: the state encodings, the opcode constants (NOP..HALT) and the AluOp codes reside in a shared package vsm_pkg, reused by the datapath blocks.
REQ-035 SHALL: the opcode-to-control decode sits in one combinational sub-module vsm_op_decode; the FSM and IR stay in vsm_control_unit.

Verification
REQ-036 SHALL: reset, then Start=1 for 1 cycle with IB=1 in FETCH -> MemRead+LatchIR, then PcInc, then MemRead+LatchA on cycles 1,2,3; back in FETCH on cycle 4.
REQ-037 SHALL: IB=5 (STA) -> EXEC1 EnableA=1, MemWrite=0; EXEC2 EnableA=1, MemWrite=1; FETCH follows 4 cycles after the previous FETCH.
REQ-038 SHALL: program 3,4,6 -> AluOp 00 then 01 with AluEnable+LatchA; then ClearA=1 with LatchA=0.
REQ-039 SHALL: IB=A -> IllegalOp=1 for exactly 1 cycle, no other control asserted, then FETCH.
REQ-040 SHALL: IB=F -> Halted=1 stays set through 10 cycles of Start toggling; ResetN pulse -> Halted=0, IDLE.
REQ-041 SHALL: ResetN asserted in EXEC2 of STA mid-cycle -> all outputs 0 immediately with no MemWrite edge; bench asserts REQ-028 exclusivity on every cycle of every test.
